// File: rtl/spi_xfer_seq_if.sv
// rtl/spi_xfer_seq_if.sv - register bus between the transfer sequencer and the SPI master
interface spi_xfer_seq_if;
    logic        spi_we_o;
    logic [31:0] spi_addr_o;
    logic [31:0] spi_wdata_o;
    logic [31:0] spi_rdata_i;

    modport master (
        output spi_we_o,
        output spi_addr_o,
        output spi_wdata_o,
        input  spi_rdata_i
    );

    modport slave (
        input  spi_we_o,
        input  spi_addr_o,
        input  spi_wdata_o,
        output spi_rdata_i
    );
endinterface

// File: rtl/spi_xfer_seq.sv
// rtl/spi_xfer_seq.sv - SPI read-transaction sequencer over a register bus; optional watchdog via SPI_SEQ_TIMEOUT_EN
module spi_xfer_seq (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            cmd,
    input  logic [23:0]           addr,
    input  logic [7:0]            len,
    input  logic [7:0]            clk_div,
    input  logic                  cpol,
    input  logic                  cpha,
    spi_xfer_seq_if.master        bus,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [31:0] REG_CTRL   = 32'h0;
    localparam logic [31:0] REG_DATA   = 32'h4;
    localparam logic [31:0] REG_STATUS = 32'h8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_DATA  = 3'd1,
        WR_CTRL  = 3'd2,
        WAIT_BSY = 3'd3,
        WAIT_IDL = 3'd4,
        CAPTURE  = 3'd5,
        CS_OFF   = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  idx_q, idx_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

    logic [7:0]  tx_byte;
    logic [31:0] ctrl_word;
    logic        status_busy;
    logic        timeout_hit;
    logic [23:0] unused_rdata;

    // Only the low byte (data) and bit 0 (busy) of the read bus carry meaning here.
    assign unused_rdata = bus.spi_rdata_i[31:8];
    assign status_busy  = bus.spi_rdata_i[0];

    // CTRL image: divider, enable bit 3, phase/polarity, chip-select/go bit 0.
    assign ctrl_word = {16'h0, clk_div, 4'b0, 1'b1, cpha, cpol, 1'b1};

`ifdef SPI_SEQ_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;
    logic        tmo_q, tmo_d;
    logic        wait_st;
    logic        status_evt;

    assign wait_st     = (state_q == WAIT_BSY) || (state_q == WAIT_IDL);
    assign status_evt  = ((state_q == WAIT_BSY) &&  status_busy) ||
                         ((state_q == WAIT_IDL) && !status_busy);
    // The watchdog only fires when the status bit did not already move us on this cycle.
    assign timeout_hit = wait_st && !status_evt && (wdog_q == 16'hFFFF);
    assign err         = (state_q == DONE) && tmo_q;

    // Watchdog: restart when a transfer is kicked off, count while polling STATUS, remember expiry.
    always_comb begin
        wdog_d = wdog_q;
        tmo_d  = tmo_q;
        if ((state_q == IDLE) && start) begin
            tmo_d = 1'b0;
        end
        if (state_q == WR_CTRL) begin
            wdog_d = 16'h0;
        end else if (wait_st && (wdog_q != 16'hFFFF)) begin
            wdog_d = wdog_q + 16'd1;
        end
        if (timeout_hit) begin
            tmo_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= 16'h0;
            tmo_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            tmo_q  <= tmo_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // Byte to shift out for the current index: command, three address bytes, then dummy zeros.
    always_comb begin
        tx_byte = 8'h00;
        case (idx_q)
            9'd0:    tx_byte = cmd_q;
            9'd1:    tx_byte = addr_q[23:16];
            9'd2:    tx_byte = addr_q[15:8];
            9'd3:    tx_byte = addr_q[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    // Next-state and datapath updates for the transaction sequence.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        len_d      = len_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cmd_d   = cmd;
                    addr_d  = addr;
                    len_d   = len;
                    idx_d   = 9'd0;
                    state_d = WR_DATA;
                end
            end
            WR_DATA: state_d = WR_CTRL;
            WR_CTRL: state_d = WAIT_BSY;
            WAIT_BSY: begin
                if (status_busy) begin
                    state_d = WAIT_IDL;
                end else if (timeout_hit) begin
                    state_d = CS_OFF;
                end
            end
            WAIT_IDL: begin
                if (!status_busy) begin
                    state_d = CAPTURE;
                end else if (timeout_hit) begin
                    state_d = CS_OFF;
                end
            end
            CAPTURE: begin
                // Header bytes clock out junk on MISO; only payload bytes are reported.
                if (idx_q >= 9'd4) begin
                    rd_data_d  = bus.spi_rdata_i[7:0];
                    rd_valid_d = 1'b1;
                end
                idx_d = idx_q + 9'd1;
                if ((idx_q + 9'd1) < (9'd4 + {1'b0, len_q})) begin
                    state_d = WR_DATA;
                end else begin
                    state_d = CS_OFF;
                end
            end
            CS_OFF:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 9'd0;
            cmd_q      <= 8'h0;
            addr_q     <= 24'h0;
            len_q      <= 8'h0;
            rd_data_q  <= 8'h0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Register-bus drive decoded from the current state; idle bus is all zeros.
    always_comb begin
        bus.spi_we_o    = 1'b0;
        bus.spi_addr_o  = REG_CTRL;
        bus.spi_wdata_o = 32'h0;
        case (state_q)
            WR_DATA: begin
                bus.spi_we_o    = 1'b1;
                bus.spi_addr_o  = REG_DATA;
                bus.spi_wdata_o = {24'h0, tx_byte};
            end
            WR_CTRL: begin
                bus.spi_we_o    = 1'b1;
                bus.spi_addr_o  = REG_CTRL;
                bus.spi_wdata_o = ctrl_word;
            end
            WAIT_BSY, WAIT_IDL: begin
                bus.spi_addr_o  = REG_STATUS;
            end
            CAPTURE: begin
                bus.spi_addr_o  = REG_DATA;
            end
            CS_OFF: begin
                // Same CTRL image with enable and chip-select dropped.
                bus.spi_we_o    = 1'b1;
                bus.spi_addr_o  = REG_CTRL;
                bus.spi_wdata_o = ctrl_word & ~32'h0000_0009;
            end
            default: begin
                bus.spi_we_o    = 1'b0;
            end
        endcase
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb/tb_spi_xfer_seq.sv - self-checking bench for spi_xfer_seq with a behavioural SPI master
`timescale 1ns/1ps
module tb_spi_xfer_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cmd = 8'h0;
    logic [23:0] addr = 24'h0;
    logic [7:0]  len = 8'h0;
    logic [7:0]  clk_div = 8'h0;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        err;

    spi_xfer_seq_if bus();

    spi_xfer_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmd      (cmd),
        .addr     (addr),
        .len      (len),
        .clk_div  (clk_div),
        .cpol     (cpol),
        .cpha     (cpha),
        .bus      (bus),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Behavioural SPI master: a started transfer reports busy for a few cycles, then
    // returns resp[k] for the k-th transfer of the transaction.
    logic [7:0]  resp [0:259];
    logic        stuck = 1'b0;
    int unsigned busy_cnt = 0;
    int unsigned xfer_n = 0;
    logic [7:0]  rx = 8'h0;

    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 0;
            xfer_n   <= 0;
            rx       <= 8'h0;
        end else begin
            if (bus.spi_we_o && bus.spi_addr_o == 32'h0 && bus.spi_wdata_o[3] && bus.spi_wdata_o[0]) begin
                busy_cnt <= $urandom_range(6, 3);
                rx       <= resp[xfer_n];
                xfer_n   <= xfer_n + 1;
            end else if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
            end
            if (done) xfer_n <= 0;
        end
    end

    always_comb begin
        bus.spi_rdata_i = 32'h0;
        if (bus.spi_addr_o == 32'h8)
            bus.spi_rdata_i = {31'h0, (busy_cnt != 0) && !stuck};
        else if (bus.spi_addr_o == 32'h4)
            bus.spi_rdata_i = {24'h0, rx};
    end

    // Bus/output monitor.
    logic [7:0]  dq [$];
    logic [31:0] cq [$];
    logic [7:0]  rq [$];
    int done_n = 0, err_n = 0, errdone_n = 0, bad_n = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.spi_we_o && bus.spi_addr_o == 32'h4) dq.push_back(bus.spi_wdata_o[7:0]);
            if (bus.spi_we_o && bus.spi_addr_o == 32'h0) cq.push_back(bus.spi_wdata_o);
            if (rd_valid) rq.push_back(rd_data);
            if (done) done_n = done_n + 1;
            if (err) err_n = err_n + 1;
            if (err && done) errdone_n = errdone_n + 1;
            if (!bus.spi_we_o && bus.spi_wdata_o != 32'h0) bad_n = bad_n + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input logic [7:0] c, input logic [23:0] a);
        if (i == 0) return c;
        if (i == 1) return a[23:16];
        if (i == 2) return a[15:8];
        if (i == 3) return a[7:0];
        return 8'h00;
    endfunction

    task automatic fill_resp();
        for (int i = 0; i < 260; i++) resp[i] = 8'($urandom_range(255, 0));
    endtask

    task automatic run_xfer(input logic [7:0] c, input logic [23:0] a, input logic [7:0] l, input bit reassert);
        int d0, c0, r0, dn0, en0, nd, nc, nr, total;
        logic [31:0] on_w, off_w;
        bit got;
        d0 = dq.size(); c0 = cq.size(); r0 = rq.size(); dn0 = done_n; en0 = err_n;
        total = 4 + int'(l);
        on_w  = (32'(clk_div) << 8) | 32'h8 | (32'(cpha) << 2) | (32'(cpol) << 1) | 32'h1;
        off_w = on_w & ~32'h9;
        @(posedge clk); #1;
        cmd = c; addr = a; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cmd = 8'($urandom); addr = 24'($urandom); len = 8'($urandom);
        got = 1'b0;
        for (int k = 0; k < 6000 && !got; k++) begin
            @(posedge clk); #1;
            start = (reassert && k == 10);
            if (done_n > dn0) got = 1'b1;
        end
        start = 1'b0;
        chk("xfer_completed", 32'(got), 32'h1);
        chk("done_count", done_n - dn0, 1);
        chk("err_count", err_n - en0, 0);
        chk("busy_after_done", 32'(busy), 32'h0);
        nd = dq.size() - d0; nc = cq.size() - c0; nr = rq.size() - r0;
        chk("data_write_count", nd, total);
        for (int i = 0; i < nd && i < total; i++)
            chk($sformatf("data_byte[%0d]", i), dq[d0 + i], exp_byte(i, c, a));
        chk("ctrl_write_count", nc, total + 1);
        for (int i = 0; i < nc && i < total + 1; i++)
            chk($sformatf("ctrl_word[%0d]", i), cq[c0 + i], (i < total) ? on_w : off_w);
        chk("rd_valid_count", nr, int'(l));
        for (int i = 0; i < nr && i < int'(l); i++)
            chk($sformatf("rd_data[%0d]", i), rq[r0 + i], resp[4 + i]);
    endtask

    initial begin
        int dn0;
        bit found;
        fill_resp();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(bus.spi_we_o), 0);
        chk("rst_addr", bus.spi_addr_o, 0);
        chk("rst_wdata", bus.spi_wdata_o, 0);
        chk("rst_outs", {rd_data, rd_valid, busy, done, err}, 0);
        rst = 1'b0;

        // Reference read: cmd 0x03 at 0x123456, two payload bytes.
        clk_div = 8'h10; cpol = 1'b0; cpha = 1'b0;
        fill_resp(); resp[4] = 8'hA5; resp[5] = 8'h5A;
        run_xfer(8'h03, 24'h123456, 8'd2, 1'b0);

        // Mode 3 with divider 3: explicit CTRL images.
        clk_div = 8'h03; cpol = 1'b1; cpha = 1'b1;
        fill_resp();
        run_xfer(8'h0B, 24'hABCDEF, 8'd1, 1'b0);
        chk("ctrl_on_const", cq[cq.size() - 2], 32'h0000030F);
        chk("ctrl_off_const", cq[cq.size() - 1], 32'h00000306);

        // Header-only transaction.
        clk_div = 8'h01; cpol = 1'b0; cpha = 1'b1;
        fill_resp();
        run_xfer(8'h06, 24'h000000, 8'd0, 1'b0);

        // Start pulsed mid-transaction must be ignored.
        fill_resp();
        run_xfer(8'h3B, 24'h00FF00, 8'd3, 1'b1);

        // Reset while waiting for the transfer to finish.
        fill_resp();
        dn0 = done_n;
        @(posedge clk); #1;
        cmd = 8'h9F; addr = 24'h111111; len = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (bus.spi_addr_o == 32'h8 && bus.spi_rdata_i[0]) found = 1'b1;
        end
        chk("reached_wait", 32'(found), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_we", 32'(bus.spi_we_o), 0);
        chk("midrst_addr", bus.spi_addr_o, 0);
        chk("midrst_wdata", bus.spi_wdata_o, 0);
        chk("midrst_outs", {rd_data, rd_valid, busy, done, err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_no_done", done_n - dn0, 0);
        fill_resp();
        run_xfer(8'h05, 24'h2468AC, 8'd2, 1'b0);

        // Randomised transactions.
        for (int t = 0; t < 6; t++) begin
            clk_div = 8'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
            fill_resp();
            run_xfer(8'($urandom), 24'($urandom), 8'($urandom_range(8, 0)), 1'b0);
        end

        // Longest transaction.
        clk_div = 8'h02; cpol = 1'b1; cpha = 1'b0;
        fill_resp();
        run_xfer(8'hEB, 24'hFEDCBA, 8'd255, 1'b0);

        chk("we_low_wdata_zero", bad_n, 0);

`ifdef SPI_SEQ_TIMEOUT_EN
        begin
            int d0, c0, en0, ed0, cyc;
            bit got;
            stuck = 1'b1;
            dn0 = done_n; d0 = dq.size(); c0 = cq.size(); en0 = err_n; ed0 = errdone_n;
            @(posedge clk); #1;
            cmd = 8'h03; addr = 24'h000100; len = 8'd2; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            got = 1'b0; cyc = 0;
            for (int k = 0; k < 70000 && !got; k++) begin
                @(posedge clk); #1;
                cyc++;
                if (done_n > dn0) got = 1'b1;
            end
            chk("tmo_completed", 32'(got), 1);
            chk("tmo_waited", 32'(cyc >= 65535), 1);
            chk("tmo_done_count", done_n - dn0, 1);
            chk("tmo_err_with_done", errdone_n - ed0, 1);
            chk("tmo_err_count", err_n - en0, 1);
            chk("tmo_data_writes", dq.size() - d0, 1);
            chk("tmo_ctrl_writes", cq.size() - c0, 2);
            chk("tmo_cs_off_bits", cq[cq.size() - 1] & 32'h9, 0);
            stuck = 1'b0;
        end
`else
        chk("err_never", err_n, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_xfer_seq.md
SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

Interface
REQ-001 SHALL have port clk  input  1  single clock for all logic; rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port start  input  1  one-cycle request; sampled only in IDLE.
REQ-004 SHALL have port cmd  input  8  command byte, latched on accepted start.
REQ-005 SHALL have port addr  input  24  device address, latched on accepted start, sent MSB byte first.
REQ-006 SHALL have port len  input  8  read byte count after header (0..255), latched on accepted start.
REQ-007 SHALL have port clk_div  input  8  copied to CTRL[15:8] on every CTRL write.
REQ-008 SHALL have port cpol  input  1  copied to CTRL[1].
REQ-009 SHALL have port cpha  input  1  copied to CTRL[2].
REQ-010 SHALL have port spi_we_o  output  1  register write strobe to SPI master.
REQ-011 SHALL have port spi_addr_o  output  32  register address to SPI master (0x0 CTRL, 0x4 DATA, 0x8 STATUS).
REQ-012 SHALL have port spi_wdata_o  output  32  register write data to SPI master.
REQ-013 SHALL have port spi_rdata_i  input  32  combinational register read data from SPI master.
REQ-014 SHALL have port rd_data  output  8  received payload byte.
REQ-015 SHALL have port rd_valid  output  1  one-cycle qualifier for rd_data.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-018 SHALL have port err  output  1  one-cycle pulse with done on timeout; constant 0 when timeout is compiled out.

Function
REQ-019 SHALL implement states IDLE, WR_DATA, WR_CTRL, WAIT_BSY, WAIT_IDL, CAPTURE, CS_OFF, DONE.
REQ-020 SHALL in IDLE on start=1 latch cmd/addr/len, clear byte counter (9 bits), go WR_DATA next cycle.
REQ-021 SHALL send byte sequence: index 0 cmd, 1 addr[23:16], 2 addr[15:8], 3 addr[7:0], 4..3+len 0x00.
REQ-022 SHALL in WR_DATA drive spi_we_o=1, spi_addr_o=0x4, spi_wdata_o={24'h0,byte[index]} for exactly one cycle, then WR_CTRL.
REQ-023 SHALL in WR_CTRL drive spi_we_o=1, spi_addr_o=0x0, spi_wdata_o={16'h0,clk_div,4'b0,1'b1,cpha,cpol,1'b1} for one cycle, then WAIT_BSY.
REQ-024 SHALL in WAIT_BSY drive spi_addr_o=0x8, spi_we_o=0; move to WAIT_IDL on first cycle spi_rdata_i[0]=1.
REQ-025 SHALL in WAIT_IDL drive spi_addr_o=0x8; move to CAPTURE on first cycle spi_rdata_i[0]=0.
REQ-026 SHALL in CAPTURE drive spi_addr_o=0x4; if index>=4 register rd_data=spi_rdata_i[7:0] with rd_valid=1 next cycle; header bytes produce no rd_valid.
REQ-027 SHALL after CAPTURE increment index; if index+1 < 4+len go WR_DATA, else CS_OFF.
REQ-028 SHALL in CS_OFF write CTRL with bits [3] and [0] both 0 (other fields as REQ-023) for one cycle, then DONE.
REQ-029 SHALL in DONE pulse done=1 for one cycle, return to IDLE.
REQ-030 SHALL ignore start in every state other than IDLE; no queuing.
REQ-031 SHALL keep spi_we_o=0 and spi_wdata_o=0 in all states other than WR_DATA, WR_CTRL, CS_OFF.
REQ-032 SHALL treat len=0 as header-only: 4 bytes, zero rd_valid pulses, then done.

Reset
REQ-033 SHALL on rst=1, asynchronously, force state IDLE, counter 0, latched fields 0, and all outputs 0 (spi_addr_o=0x0).
REQ-034 SHALL abort any transaction on reset mid-operation with no done pulse; chip-select recovery is the SPI master's own reset.

Configuration
REQ-035 SHALL with SPI_SEQ_TIMEOUT_EN defined include a 16-bit watchdog cleared on WAIT_BSY entry, counting in WAIT_BSY/WAIT_IDL; at 0xFFFF go CS_OFF, then DONE with err=1 alongside done.
REQ-036 SHALL without SPI_SEQ_TIMEOUT_EN omit the watchdog, wait indefinitely, and tie err to 0.

Verification
REQ-037 cmd=0x03, addr=0x123456, len=2, model returns 0xA5,0x5A -> DATA writes 0x03,0x12,0x34,0x56,0x00,0x00; rd_valid twice with 0xA5 then 0x5A; one done.
REQ-038 len=0, cmd=0x06 -> four DATA/CTRL pairs, no rd_valid, CS_OFF CTRL write with bit3=0, done once.
REQ-039 start reasserted mid-transaction -> ignored; byte count and done count unchanged.
REQ-040 rst asserted in WAIT_IDL -> all outputs 0 immediately; next start begins fresh at index 0 with cmd byte.
REQ-041 clk_div=0x03, cpol=1, cpha=1 -> every CTRL write data = 0x0000030F; CS_OFF write = 0x00000306.
REQ-042 with SPI_SEQ_TIMEOUT_EN, STATUS[0] stuck 0 -> after 65535 wait cycles CS_OFF write, then done=1 and err=1 same cycle.
